// File: rtl/demux_pkg.sv
// demux_pkg: shared channel count, select width, FSM states and counter limits for the 1-to-8 demux controller
package demux_pkg;
  localparam int NCH = 8;
  localparam int SELW = 3;
  localparam int STAT_W = 8;
  localparam logic [STAT_W-1:0] STAT_MAX = 8'hFF;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/demux81_comb.sv
// demux81_comb: one-hot 1-to-8 decode of a single enable bit onto output sel
module demux81_comb
  import demux_pkg::*;
(
  input  logic            in,
  input  logic [SELW-1:0] sel,
  output logic [NCH-1:0]  y
);
  assign y = {{(NCH-1){1'b0}}, in} << sel;
endmodule

// File: rtl/demux81_stats.sv
// demux81_stats: per-channel saturating handshake counters with synchronous clear and indexed read
module demux81_stats
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    inc_vec,
  input  logic              clr,
  input  logic [SELW-1:0]   rd_sel,
  output logic [STAT_W-1:0] rd_cnt
);
  logic [STAT_W-1:0] cnt_q [NCH];
  logic [STAT_W-1:0] cnt_d [NCH];
  always_comb begin
    for (int i = 0; i < NCH; i++)
      cnt_d[i] = clr ? '0 : (inc_vec[i] && cnt_q[i] != STAT_MAX) ? cnt_q[i] + 1'b1 : cnt_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    else cnt_q <= cnt_d;
  end
  assign rd_cnt = cnt_q[rd_sel];
endmodule

// File: rtl/demux81_sched.sv
// demux81_sched: valid/ready sequencer feeding a 1-to-8 demux, round-robin or tag-directed
// Optional per-channel transfer counters enabled by DEMUX81_SCHED_STATS_EN.
module demux81_sched
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SELW-1:0]   in_dest,
  input  logic              mode,
  output logic [SELW-1:0]   sel,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              busy,
  input  logic [SELW-1:0]   stat_sel,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_cnt
);
  state_t state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d, rr_q, rr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic accept, hs;
  assign busy = state_q == SEND;
  assign sel = sel_q;
  assign out_data = data_q;
  assign hs = busy & out_ready[sel_q];
  // Refill in the same cycle the held word drains, so a ready channel sees no bubble.
  assign in_ready = ~busy | out_ready[sel_q];
  assign accept = in_valid & in_ready;
  demux81_comb u_dec (.in(busy), .sel(sel_q), .y(out_valid));
  always_comb begin
    state_d = accept ? SEND : hs ? IDLE : state_q;
    sel_d = accept ? (mode ? in_dest : rr_q) : sel_q;
    rr_d = (accept && !mode) ? rr_q + 1'b1 : rr_q;
    data_d = accept ? in_data : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= '0;
      rr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      rr_q <= rr_d;
      data_q <= data_d;
    end
  end
`ifdef DEMUX81_SCHED_STATS_EN
  demux81_stats u_stats (
    .clk(clk), .rst(rst), .inc_vec(out_valid & out_ready), .clr(stat_clr),
    .rd_sel(stat_sel), .rd_cnt(stat_cnt)
  );
`else
  logic unused_stats;
  assign unused_stats = ^{stat_sel, stat_clr};
  assign stat_cnt = '0;
`endif
endmodule
